// File: rtl/serial_word_assembler_pkg.sv
// Shared constants for the deserializer and the downstream comma-code locator.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package serial_word_assembler_pkg;

  // Word width and bit-counter width, shared with the comma-code locator
  localparam int WORD_SIZE  = 16;
  localparam int COUNT_SIZE = 5;

  // FSM state encoding
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;

endpackage

// File: rtl/serial_word_assembler_if.sv
// Bit-stream in / word-out bundle between the serial source and the assembler.
// Latency: n/a (wiring only).
// Backpressure: none; the source is qualified by bit_valid only.
interface serial_word_assembler_if
  import serial_word_assembler_pkg::*;
#(
  parameter int WORD_SIZE_P = WORD_SIZE
);

  logic                   serial_in;
  logic                   bit_valid;
  logic                   start;
  logic                   continuous;
  logic [WORD_SIZE_P-1:0] word_out;
  logic                   trigger;
  logic                   busy;
  logic [7:0]             word_count;

  // Serial source / stimulus side
  modport master (
    output serial_in, bit_valid, start, continuous,
    input  word_out, trigger, busy, word_count
  );

  // Assembler side
  modport slave (
    input  serial_in, bit_valid, start, continuous,
    output word_out, trigger, busy, word_count
  );

endinterface

// File: rtl/serial_word_assembler.sv
// Collects an MSB-first serial stream into words and pulses trigger per word.
// Latency: word_out/trigger update on the edge that samples the last bit.
// Backpressure: none; gaps in bit_valid simply stall collection.
module serial_word_assembler
  import serial_word_assembler_pkg::*;
#(
  parameter int word_size  = WORD_SIZE,
  parameter int count_size = COUNT_SIZE
) (
  input  logic                     clk,
  input  logic                     rst,
  serial_word_assembler_if.slave   bus
);

  logic [0:0]            state_q, state_d;
  logic [word_size-1:0]  shift_q, shift_d;
  logic [count_size-1:0] cnt_q,   cnt_d;
  logic [word_size-1:0]  word_q,  word_d;
  logic                  trig_q,  trig_d;
  logic [7:0]            count_q, count_d;

  logic [word_size-1:0]  shifted;
  logic                  last_bit;

  // Shift register contents if the current bit were accepted
  assign shifted  = {shift_q[word_size-2:0], bus.serial_in};
  // The counter never reaches word_size; word_size-1 marks the final bit
  assign last_bit = (cnt_q == count_size'(word_size - 1));

  // Next-state: start (resync) outranks completion; IDLE ignores bare bit_valid
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    trig_d  = 1'b0;
    count_d = count_q;
    if (bus.start) begin
      state_d = ST_COLLECT;
      cnt_d   = '0;
      if (bus.bit_valid) begin
        shift_d = shifted;
        cnt_d   = count_size'(1);
      end
    end else if (state_q == ST_COLLECT && bus.bit_valid) begin
      shift_d = shifted;
      if (last_bit) begin
        word_d  = shifted;
        trig_d  = 1'b1;
        count_d = count_q + 8'd1;
        cnt_d   = '0;
        state_d = bus.continuous ? ST_COLLECT : ST_IDLE;
      end else begin
        cnt_d = cnt_q + count_size'(1);
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      trig_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      trig_q  <= trig_d;
      count_q <= count_d;
    end
  end

  assign bus.word_out   = word_q;
  assign bus.trigger    = trig_q;
  assign bus.busy       = (state_q == ST_COLLECT);
  assign bus.word_count = count_q;

endmodule

// File: tb/tb_serial_word_assembler.sv
module tb_serial_word_assembler;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  serial_word_assembler_if #(.WORD_SIZE_P(16)) bus ();

  serial_word_assembler #(.word_size(16), .count_size(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] word;
    int          gap;
    logic        cont;
    logic        st;
    int          exp_trig;
    logic [15:0] exp_word;
    logic        exp_busy;
    logic [7:0]  exp_count;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one 16-bit word MSB first; optional gap of 'gap' idle cycles after every 4th bit
  task automatic run_frame(input logic [15:0] w, input int gap, input logic cont, input logic st,
                           output int trig_rel, output int ntrig, output logic busy_during);
    int rel;
    rel = 0;
    trig_rel = -1;
    ntrig = 0;
    busy_during = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.start = st && (i == 0);
      bus.bit_valid = 1'b1;
      bus.serial_in = w[15-i];
      bus.continuous = cont;
      step();
      if (bus.trigger) begin
        if (trig_rel < 0) trig_rel = rel;
        ntrig++;
      end
      if (i < 15) busy_during &= bus.busy;
      rel++;
      if (gap > 0 && (i % 4) == 3 && i != 15) begin
        for (int g = 0; g < gap; g++) begin
          bus.start = 1'b0;
          bus.bit_valid = 1'b0;
          step();
          if (bus.trigger) begin
            if (trig_rel < 0) trig_rel = rel;
            ntrig++;
          end
          busy_during &= bus.busy;
          rel++;
        end
      end
    end
    bus.start = 1'b0;
    bus.bit_valid = 1'b0;
  endtask

  initial begin
    int tr, nt, tot;
    logic bd;
    logic [15:0] pw;

    vecs[0] = '{16'hA5C3, 0, 1'b0, 1'b1, 15, 16'hA5C3, 1'b0, 8'd1};
    vecs[1] = '{16'hA5C3, 3, 1'b0, 1'b1, 24, 16'hA5C3, 1'b0, 8'd2};
    vecs[2] = '{16'h0005, 0, 1'b1, 1'b1, 15, 16'h0005, 1'b1, 8'd3};
    vecs[3] = '{16'hFFFF, 0, 1'b0, 1'b0, 15, 16'hFFFF, 1'b0, 8'd4};
    vecs[4] = '{16'h8001, 1, 1'b0, 1'b1, 18, 16'h8001, 1'b0, 8'd5};

    rst = 1'b1;
    bus.serial_in = 1'b0;
    bus.bit_valid = 1'b0;
    bus.start = 1'b0;
    bus.continuous = 1'b0;
    step();
    step();
    check("reset word_out", 32'(bus.word_out), 32'h0);
    check("reset trigger", 32'(bus.trigger), 32'h0);
    check("reset busy", 32'(bus.busy), 32'h0);
    check("reset word_count", 32'(bus.word_count), 32'h0);
    rst = 1'b0;

    // bit_valid without start is ignored in IDLE
    nt = 0;
    bus.bit_valid = 1'b1;
    bus.serial_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.trigger || bus.busy) nt++;
    end
    bus.bit_valid = 1'b0;
    check("idle ignores bits", 32'(nt), 32'h0);

    // Table-driven frames
    for (int v = 0; v < 5; v++) begin
      run_frame(vecs[v].word, vecs[v].gap, vecs[v].cont, vecs[v].st, tr, nt, bd);
      if (!vecs[v].cont) begin
        step();
        if (bus.trigger) nt++;
        check($sformatf("v%0d busy idle", v), 32'(bus.busy), 32'h0);
      end
      check($sformatf("v%0d trig cycle", v), 32'(tr), 32'(vecs[v].exp_trig));
      check($sformatf("v%0d trig count", v), 32'(nt), 32'h1);
      check($sformatf("v%0d word_out", v), 32'(bus.word_out), 32'(vecs[v].exp_word));
      check($sformatf("v%0d word_count", v), 32'(bus.word_count), 32'(vecs[v].exp_count));
      check($sformatf("v%0d busy during", v), 32'(bd), 32'h1);
      check($sformatf("v%0d busy at end", v), 32'(bus.busy), 32'(vecs[v].exp_busy));
    end

    // Resync: 10 bits of a partial word, then start with a new bit
    pw = 16'hFFFF;
    nt = 0;
    for (int i = 0; i < 10; i++) begin
      bus.start = (i == 0);
      bus.bit_valid = 1'b1;
      bus.serial_in = pw[15-i];
      bus.continuous = 1'b0;
      step();
      if (bus.trigger) nt++;
    end
    check("resync partial no trigger", 32'(nt), 32'h0);
    check("resync word_out held", 32'(bus.word_out), 32'h8001);
    run_frame(16'h1234, 0, 1'b0, 1'b1, tr, nt, bd);
    check("resync trig cycle", 32'(tr), 32'd15);
    check("resync trig count", 32'(nt), 32'h1);
    check("resync word_out", 32'(bus.word_out), 32'h1234);
    check("resync word_count", 32'(bus.word_count), 32'd6);

    // Reset after 7 bits
    step();
    nt = 0;
    for (int i = 0; i < 7; i++) begin
      bus.start = (i == 0);
      bus.bit_valid = 1'b1;
      bus.serial_in = 1'b1;
      step();
      if (bus.trigger) nt++;
    end
    rst = 1'b1;
    step();
    if (bus.trigger) nt++;
    check("midrst word_out", 32'(bus.word_out), 32'h0);
    check("midrst busy", 32'(bus.busy), 32'h0);
    check("midrst word_count", 32'(bus.word_count), 32'h0);
    check("midrst no trigger", 32'(nt), 32'h0);
    rst = 1'b0;
    bus.bit_valid = 1'b0;
    run_frame(16'hC0DE, 0, 1'b0, 1'b1, tr, nt, bd);
    check("post-rst trig cycle", 32'(tr), 32'd15);
    check("post-rst word_out", 32'(bus.word_out), 32'hC0DE);
    check("post-rst word_count", 32'(bus.word_count), 32'd1);

    // Count wrap: 255 more words in continuous mode
    step();
    tot = 0;
    for (int k = 2; k <= 256; k++) begin
      run_frame(16'(k), 0, (k != 256), (k == 2), tr, nt, bd);
      tot += nt;
      if (k == 255) check("count at 255", 32'(bus.word_count), 32'd255);
    end
    check("wrap trigger total", 32'(tot), 32'd255);
    check("wrap word_count", 32'(bus.word_count), 32'h0);
    check("wrap word_out", 32'(bus.word_out), 32'h0100);
    step();
    check("wrap busy idle", 32'(bus.busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_word_assembler.md
# serial_word_assembler

Deserializer that sits directly upstream of the comma-code locator. It collects a serial bit stream into `word_size`-bit words, MSB first. For each complete word it presents the word on `word_out` and issues a one-cycle `trigger` pulse. The comma-code locator consumes these on the rising edge of `trigger`. The block also handles frame start and resynchronisation, optional back-to-back word collection, and a running word count.

## Interface
- `word_size`, 16, bits per assembled word; must be ≥ 3.
- `count_size`, 5, bit-counter width; must satisfy 2^`count_size` > `word_size`.
- `clk`  input  1  single clock; all state changes on its rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `serial_in`  input  1  data bit; sampled only when `bit_valid`=1.
- `bit_valid`  input  1  qualifies `serial_in` for this cycle.
- `start`  input  1  begins a new frame; discards any partial word.
- `continuous`  input  1  sampled at word completion; 1 = keep collecting, 0 = return to IDLE.
- `word_out`  output  `word_size`  last completed word; held until the next completion.
- `trigger`  output  1  one-cycle pulse marking a new `word_out`.
- `busy`  output  1  high while in COLLECT.
- `word_count`  output  8  number of completed words since reset; wraps from 255 to 0.

## Operation
- Reset values: `word_out` = 0, `trigger` = 0, `busy` = 0, `word_count` = 0.
- Reset also clears the internal shift register and bit counter, and sets the state to IDLE.
- `rst` overrides every other input in the same cycle.
- The FSM has two states: IDLE and COLLECT.
- **IDLE:**
  - `bit_valid` is ignored unless `start` is also 1.
  - `start`=1 moves the FSM to COLLECT and sets the bit counter to 0.
  - If `bit_valid`=1 in the same cycle as `start`, that bit is accepted as bit 0 and the counter becomes 1.
- **COLLECT, per accepted bit:**
  - shift register ← {shift[`word_size`-2:0], `serial_in`}.
  - The bit counter increments by 1.
  - Gaps in `bit_valid` simply hold the shift register and counter.
- **Completion** occurs when the bit accepted this cycle is bit `word_size`-1:
  - `word_out` ← the fully shifted word, including this bit.
  - `trigger` is set to 1 for one cycle.
  - `word_count` increments, modulo 256.
  - The bit counter resets to 0.
  - If `continuous`=1, the FSM stays in COLLECT; otherwise it goes to IDLE.
- **`start`=1 while in COLLECT (resync):**
  - The partial word is discarded and the counter goes to 0.
  - If `bit_valid` is also 1, the current bit becomes bit 0 of the new word.
  - `start` takes priority over completion: no trigger is issued and `word_out` is unchanged.
- `busy` is registered and equals (state == COLLECT).
- `trigger` is registered, and is 0 in every cycle that is not a completion.

## Timing
- Latency: the rising edge that samples the last bit also updates `word_out` and sets `trigger`. Both are visible during the following cycle.
- `trigger` is exactly one `clk` period wide. It is never high in two consecutive cycles, because `word_size` ≥ 3.
- Trigger spacing:
  - Minimum is `word_size` cycles, with `bit_valid` held continuously at 1 in continuous mode.
  - `word_out` is stable from the trigger cycle until the next completion, so the downstream stage has at least `word_size`-1 cycles after the `trigger` rising edge.
- `rst` mid-frame: on the next edge all state is cleared and `word_out` becomes 0. No trigger is produced.
- Counter arithmetic: the bit counter counts 0 to `word_size`-1 and never reaches `word_size`. `word_count` is an 8-bit unsigned counter that wraps.

## Structure
- Shared package contents:
  - FSM state encoding: IDLE = 1'b0, COLLECT = 1'b1.
  - Default constants `WORD_SIZE` = 16 and `COUNT_SIZE` = 5. These are shared with the comma-code locator, so both stages agree on word width.
- A single module is sufficient. The natural sub-module boundary is `bit_counter`, the modulo-`word_size` counter with clear and enable, which emits terminal count. Use it only if a second deserializer reuses it.

## Test plan
- **Single word:** reset, then `start` with the first bit, then feed 16'hA5C3 MSB-first with `bit_valid` constantly 1 and `continuous`=0 → `trigger` high for exactly one cycle after the 16th bit, `word_out` = 16'hA5C3, `word_count` = 1, `busy` returns to 0.
- **Gapped input:** same word, with `bit_valid` deasserted for 3 cycles after every 4th bit → identical `word_out`, with `trigger` 9 cycles later than in the gap-free case.
- **Continuous mode:** `continuous`=1, words 16'h0005 then 16'hFFFF back-to-back → two triggers exactly 16 cycles apart, `word_out` sequence 0x0005 then 0xFFFF, `busy` stays 1.
- **Resync:** after 10 bits, assert `start` together with a new bit, then feed 16'h1234 → no trigger for the partial word; next trigger shows 16'h1234.
- **Reset mid-frame:** assert `rst` after 7 bits → all outputs 0 on the next cycle and no trigger. A fresh frame then completes normally with `word_count` = 1.
- **Count wrap:** 256 completed words → `word_count` reads 0 after the 256th trigger.
